// File: rtl/c17_bist.sv
// c17_bist: LFSR pattern generator and MISR compactor that self-tests a c17 circuit
module c17_bist #(
    parameter int unsigned NUM_PATTERNS = 31,
    parameter logic [4:0]  SEED         = 5'b00001,
    parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] pat,
    input  logic [1:0] rsp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] sig
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state_q, state_d;
    logic [4:0] lfsr_q, lfsr_d, cnt_q, cnt_d;
    logic [7:0] misr_q, misr_d, misr_nx;
    logic       pass_q, pass_d;
    logic       last;
    assign misr_nx = {misr_q[6:0], 1'b0} ^ (misr_q[7] ? 8'h1D : 8'h00) ^ {6'b0, rsp};
    assign last    = cnt_q == 5'(NUM_PATTERNS - 1);
    // Next-state logic: a run is launched from IDLE or DONE, then retires one pattern per cycle
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = SEED;
                    misr_d  = 8'h00;
                    cnt_d   = 5'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                misr_d  = misr_nx;
                cnt_d   = cnt_q + 5'd1;
                lfsr_d  = last ? 5'd0 : {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
                state_d = last ? DONE : RUN;
                pass_d  = last ? (misr_nx == GOLDEN_SIG) : pass_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // State registers; reset clears everything at once, even mid-run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= 5'd0;
            misr_q  <= 8'h00;
            cnt_q   <= 5'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end
    assign pat  = lfsr_q;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign pass = pass_q;
    assign sig  = misr_q;
endmodule

// File: doc/c17_bist.md
C17_BIST -- requirements
Module: c17_bist

Interface
REQ-001 Parameter NUM_PATTERNS, default 31: number of patterns applied per run, legal range 1..31.
REQ-002 Parameter SEED, default 5'b00001: initial LFSR value; it shall be nonzero.
REQ-003 Parameter GOLDEN_SIG, default 8'h00: expected fault-free MISR signature.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: request a self-test run; sampled in IDLE and DONE only.
REQ-007 Port pat, output, 5: pattern driven to the c17 circuit under test (CUT); bit mapping [4:0] = {G1,G2,G3,G6,G7}.
REQ-008 Port rsp, input, 2: CUT response; bit mapping [1:0] = {G23,G22}.
REQ-009 Port busy, output, 1: high while in RUN.
REQ-010 Port done, output, 1: high while in DONE.
REQ-011 Port pass, output, 1: signature-compare result, valid while done=1.
REQ-012 Port sig, output, 8: current MISR contents.

Function
REQ-013 The FSM shall have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1 shall move to RUN, with LFSR<=SEED, MISR<=0 and count<=0.
REQ-015 In each RUN cycle, the MISR shall absorb rsp, the LFSR shall advance and count shall increment.
REQ-016 In the RUN cycle with count==NUM_PATTERNS-1, the block shall absorb rsp, then move to DONE with LFSR<=0.
REQ-017 pat shall be the LFSR register itself, with no combinational path; it is 0 outside RUN.
REQ-018 The CUT is combinational, so rsp shall be sampled on the same edge that retires the pattern; response latency is zero cycles.
REQ-019 The LFSR next state shall be {q[3:0], q[4]^q[2]} (polynomial x^5+x^3+1, period 31).
REQ-020 The MISR next state shall be {m[6:0],1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {6'b0, rsp}.
REQ-021 On entry to DONE, pass shall be registered as (final MISR == GOLDEN_SIG).
REQ-022 DONE shall hold done, pass and sig stable until start=1.
REQ-023 DONE with start=1 shall restart exactly as REQ-014.
REQ-024 start asserted during RUN shall be ignored; the run shall not restart.
REQ-025 start held high continuously shall produce back-to-back runs separated by exactly one DONE cycle.
REQ-026 A run shall last exactly NUM_PATTERNS cycles with busy=1.
REQ-027 count shall be 5 bits wide and shall not wrap within a legal run.

Reset
REQ-028 Asserting rst at any time, including mid-RUN, shall immediately force state=IDLE, pat=0, MISR=0, count=0, busy=0, done=0 and pass=0.
REQ-029 After rst is released, the block shall take no action until start is sampled high in IDLE.

Verification
REQ-030 Reset values: assert rst -> pat=0, sig=8'h00, busy=0, done=0, pass=0, asynchronously, with no clock edge required.
REQ-031 Pattern sequence: start for 1 cycle, SEED=1 -> pat over the first six RUN cycles = 00001, 00010, 00100, 01001, 10010, 00101; busy=1 for exactly 31 cycles; done=1 on the following cycle.
REQ-032 Golden run: rsp driven by a c17 reference model, with GOLDEN_SIG set to the model-computed signature -> done=1, pass=1, sig=GOLDEN_SIG; all held until the next start.
REQ-033 Fault detection: same configuration as REQ-032 with rsp[0] (G22) stuck at 0 -> done=1, pass=0, sig differs from GOLDEN_SIG.
REQ-034 Mid-run reset: rst pulsed in RUN cycle 10 -> IDLE immediately, pat=0, sig=0; a new start then reproduces REQ-031 from 00001.
REQ-035 Start handling: start pulsed at RUN cycle 5 -> ignored, run length still 31. NUM_PATTERNS=1 with start held high -> alternating RUN/DONE cycles, pat=00001 in every RUN cycle.
